instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/seq_phase_decoder.sv | 30 +++
 rtl/instr_sequencer.sv | 145 ++++++++++++++
 tb/tb_instr_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and phase-length table for the instruction sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_OUT  = 4'h0,
        OP_JMP  = 4'h1,
        OP_LDW  = 4'h2,
        OP_STW  = 4'h3,
        OP_RTR  = 4'h4,
        OP_BLT  = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_HALT = 4'hF
    } opc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

    // Phase counts include the FETCH phase (index 0).
    localparam int unsigned LEN_OUT     = 2;
    localparam int unsigned LEN_JMP     = 2;
    localparam int unsigned LEN_LDW     = 4;
    localparam int unsigned LEN_STW     = 4;
    localparam int unsigned LEN_RTR     = 3;
    localparam int unsigned LEN_BLT     = 3;
    localparam int unsigned LEN_ADD     = 4;
    localparam int unsigned LEN_SUB     = 4;
    localparam int unsigned LEN_ILLEGAL = 2;

    function automatic logic [1:0] last_of(input int unsigned len);
        return 2'(len - 1);
    endfunction

endpackage

// File: rtl/seq_phase_decoder.sv
// Combinational map from opcode to last EXEC phase index and illegal flag.
module seq_phase_decoder
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [1:0]       last_phase,
    output logic             illegal
);

    always_comb begin
        last_phase = last_of(LEN_ILLEGAL);
        illegal    = 1'b1;
        case (opcode)
            OPC_W'(OP_OUT): begin last_phase = last_of(LEN_OUT); illegal = 1'b0; end
            OPC_W'(OP_JMP): begin last_phase = last_of(LEN_JMP); illegal = 1'b0; end
            OPC_W'(OP_LDW): begin last_phase = last_of(LEN_LDW); illegal = 1'b0; end
            OPC_W'(OP_STW): begin last_phase = last_of(LEN_STW); illegal = 1'b0; end
            OPC_W'(OP_RTR): begin last_phase = last_of(LEN_RTR); illegal = 1'b0; end
            OPC_W'(OP_BLT): begin last_phase = last_of(LEN_BLT); illegal = 1'b0; end
            OPC_W'(OP_ADD): begin last_phase = last_of(LEN_ADD); illegal = 1'b0; end
            OPC_W'(OP_SUB): begin last_phase = last_of(LEN_SUB); illegal = 1'b0; end
            // HALT never enters EXEC, so its phase index is irrelevant.
            OPC_W'(OP_HALT): illegal = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-phase instruction sequencer: IDLE/FETCH/EXEC/HALT with per-opcode phase counts.
// Define INSTR_SEQ_RETIRE_COUNT_EN to build the retired-instruction counter.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     state_machine_reset,
    input  logic [INSTR_W-1:0]       instr_word,
    input  logic                     instr_valid,
    output logic [1:0]               state,
    output logic [OPC_W-1:0]         opcode,
    output logic [INSTR_W-OPC_W-1:0] operand,
    output logic                     busy,
    output logic                     halted,
    output logic                     illegal,
    output logic [15:0]              retired_count
);

    localparam int OPR_W = INSTR_W - OPC_W;

    seq_state_t       fsm_q, fsm_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       last_q, last_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic [OPR_W-1:0] operand_q, operand_d;
    logic             illegal_q, illegal_d;
    logic             retire;

    logic [OPC_W-1:0] fetch_opc;
    logic [1:0]       dec_last;
    logic             dec_illegal;

    assign fetch_opc = instr_word[INSTR_W-1 -: OPC_W];

    // Decoding the incoming word lets the phase limit be latched with the opcode.
    seq_phase_decoder #(.OPC_W(OPC_W)) u_dec (
        .opcode     (fetch_opc),
        .last_phase (dec_last),
        .illegal    (dec_illegal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q     <= ST_IDLE;
            phase_q   <= '0;
            last_q    <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            phase_q   <= phase_d;
            last_q    <= last_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        phase_d   = phase_q;
        last_d    = last_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        if (state_machine_reset) begin
            fsm_d   = ST_IDLE;
            phase_d = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) fsm_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (instr_valid) begin
                        opcode_d  = fetch_opc;
                        operand_d = instr_word[OPR_W-1:0];
                        if (fetch_opc == OPC_W'(OP_HALT)) begin
                            fsm_d  = ST_HALT;
                            retire = 1'b1;
                        end else begin
                            fsm_d     = ST_EXEC;
                            phase_d   = 2'd1;
                            last_d    = dec_last;
                            illegal_d = illegal_q | dec_illegal;
                        end
                    end
                end
                ST_EXEC: begin
                    if (phase_q == last_q) begin
                        fsm_d   = ST_FETCH;
                        phase_d = '0;
                        retire  = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
                ST_HALT: begin
                    if (start) fsm_d = ST_IDLE;
                end
                default: begin
                    fsm_d   = ST_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        state   = phase_q;
        opcode  = opcode_q;
        operand = operand_q;
        busy    = (fsm_q == ST_FETCH) || (fsm_q == ST_EXEC);
        halted  = (fsm_q == ST_HALT);
        illegal = illegal_q;
    end

`ifdef INSTR_SEQ_RETIRE_COUNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired_count = retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed scenarios then randomized traffic.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        state_machine_reset = 1'b0;
    logic [15:0] instr_word = '0;
    logic        instr_valid = 1'b0;
    logic [1:0]  state;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        busy, halted, illegal;
    logic [15:0] retired_count;

    instr_sequencer #(.INSTR_W(16), .OPC_W(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .state_machine_reset (state_machine_reset),
        .instr_word          (instr_word),
        .instr_valid         (instr_valid),
        .state               (state),
        .opcode              (opcode),
        .operand             (operand),
        .busy                (busy),
        .halted              (halted),
        .illegal             (illegal),
        .retired_count       (retired_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  state;
        logic [3:0]  opcode;
        logic [11:0] operand;
        logic        busy;
        logic        halted;
        logic        illegal;
        logic [15:0] retired;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: mode 0=idle 1=fetch 2=exec 3=halt, phase counts instruction steps.
    int          len_tab[16] = '{2, 2, 4, 4, 3, 3, 4, 4, 2, 2, 2, 2, 2, 2, 2, 0};
    int          m_mode = 0;
    int          m_ph = 0;
    int          m_len = 0;
    logic [3:0]  m_opc = '0;
    logic [11:0] m_opr = '0;
    logic        m_ill = 1'b0;
    logic [15:0] m_ret = '0;

    function automatic exp_t model_out();
        exp_t e;
        e.state   = 2'(m_ph);
        e.opcode  = m_opc;
        e.operand = m_opr;
        e.busy    = (m_mode == 1) || (m_mode == 2);
        e.halted  = (m_mode == 3);
        e.illegal = m_ill;
`ifdef INSTR_SEQ_RETIRE_COUNT_EN
        e.retired = m_ret;
`else
        e.retired = 16'h0000;
`endif
        return e;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic smr,
                              input logic [15:0] w, input logic v);
        if (r) begin
            m_mode = 0; m_ph = 0; m_len = 0;
            m_opc = '0; m_opr = '0; m_ill = 1'b0; m_ret = '0;
        end else if (smr) begin
            m_mode = 0; m_ph = 0;
        end else if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (v) begin
                m_opc = w[15:12];
                m_opr = w[11:0];
                if (m_opc == 4'hF) begin
                    m_mode = 3;
                    m_ret  = m_ret + 16'd1;
                end else begin
                    m_len  = len_tab[m_opc];
                    m_ill  = m_ill | (m_opc >= 4'h8);
                    m_mode = 2;
                    m_ph   = 1;
                end
            end
        end else if (m_mode == 2) begin
            m_ph = m_ph + 1;
            if (m_ph == m_len) begin
                m_mode = 1;
                m_ph   = 0;
                m_ret  = m_ret + 16'd1;
            end
        end else begin
            if (s) m_mode = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e);
        chk("state",   32'(state),         32'(e.state));
        chk("opcode",  32'(opcode),        32'(e.opcode));
        chk("operand", 32'(operand),       32'(e.operand));
        chk("busy",    32'(busy),          32'(e.busy));
        chk("halted",  32'(halted),        32'(e.halted));
        chk("illegal", 32'(illegal),       32'(e.illegal));
        chk("retired", 32'(retired_count), 32'(e.retired));
    endtask

    // Apply one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic step(input logic r, input logic s, input logic smr,
                        input logic [15:0] w, input logic v);
        logic was_reset;
        @(negedge clock);
        was_reset           = reset;
        reset               = r;
        start               = s;
        state_machine_reset = smr;
        instr_word          = w;
        instr_valid         = v;
        model_step(r, s, smr, w, v);
        if (r && !was_reset) begin
            #1;
            compare_all(model_out());
        end
        sb_q.push_back(model_out());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                compare_all(e);
            end
        end
    end

    initial begin : driver
        logic [15:0] w;
        logic [3:0]  op;
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 0);

        // opcode 6 (len 4): 0,1,2,3,0
        step(0, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h6123, 1);
        step(0, 0, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h0000, 0);
        step(0, 0, 1, 16'h0000, 0);

        // back-to-back 0100 / 0000 with valid held high
        step(0, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h4ABC, 1);
        step(0, 0, 0, 16'h0DEF, 1);
        step(0, 0, 0, 16'h0DEF, 1);
        step(0, 0, 0, 16'h0DEF, 1);
        step(0, 0, 0, 16'h0DEF, 0);

        // FETCH stall, start while busy ignored
        for (int i = 0; i < 5; i++) step(0, (i == 2), 0, 16'h7777, 0);

        // HALT then start back to IDLE
        step(0, 0, 0, 16'hF000, 1);
        step(0, 0, 0, 16'h1234, 1);
        step(0, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h0000, 0);

        // illegal opcode: len 2, sticky across state_machine_reset, cleared by reset
        step(0, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h9000, 1);
        step(0, 0, 0, 16'h0000, 0);
        step(0, 0, 1, 16'h0000, 1);
        step(0, 1, 0, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h0000, 0);

        // reset in EXEC phase 2 of opcode 0010
        step(0, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h2555, 1);
        step(0, 0, 0, 16'h0000, 0);
        step(1, 0, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h0000, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       op = 4'hF;
                1:       op = 4'(8 + $urandom_range(0, 6));
                default: op = 4'($urandom_range(0, 7));
            endcase
            w = {op, 12'($urandom())};
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0),
                 w,
                 ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 0, 16'h0000, 0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clock);
        #2;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
